// File: rtl/wishbone_req_master.sv
// rtl/wishbone_req_master.sv - single-request Wishbone master with retry, timeout and one-cycle response pulse
//
// Purpose: accepts one read or write from a core, runs it as a classic Wishbone
// cycle, retries on wb_rty_i up to MAX_RETRY times with a one-cycle bus release
// between attempts, aborts after TIMEOUT unanswered ACTIVE cycles per attempt,
// and returns the result as a one-cycle valid_o pulse.
//
// Ports:
//   clk_i, rst_i                      clock, synchronous active-high reset
//   req_i, we_i, addr_i, data_i,      core request; sampled only when ready_o=1
//   sel_i
//   ready_o                           idle, a request on req_i is taken this cycle
//   valid_o, data_o, err_o            response pulse, read data, failure flag
//   wb_cyc_o, wb_stb_o, wb_we_o,      Wishbone master outputs
//   wb_adr_o, wb_dat_o, wb_sel_o
//   wb_tgd_o, wb_tga_o, wb_tgc_o      tags, tied to 0
//   wb_dat_i, wb_tgd_i                slave read data, data tag (ignored)
//   wb_ack_i, wb_err_i, wb_rty_i      slave termination signals

module wishbone_req_master #(
    parameter int unsigned TAGSIZE   = 2,
    parameter int unsigned MAX_RETRY = 3,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic               we_i,
    input  logic [31:0]        addr_i,
    input  logic [31:0]        data_i,
    input  logic [3:0]         sel_i,
    output logic               ready_o,
    output logic               valid_o,
    output logic [31:0]        data_o,
    output logic               err_o,
    input  logic [31:0]        wb_dat_i,
    input  logic [TAGSIZE-1:0] wb_tgd_i,
    output logic [31:0]        wb_dat_o,
    output logic [TAGSIZE-1:0] wb_tgd_o,
    output logic [31:0]        wb_adr_o,
    output logic [TAGSIZE-1:0] wb_tga_o,
    output logic [TAGSIZE-1:0] wb_tgc_o,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_rty_i,
    output logic               wb_cyc_o,
    output logic               wb_stb_o,
    output logic [3:0]         wb_sel_o,
    output logic               wb_we_o
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int WW = (TIMEOUT <= 1) ? 1 : $clog2(TIMEOUT);
    localparam logic [RW-1:0] MAX_RETRY_C = RW'(MAX_RETRY);
    // Last wait count of an attempt; reaching it unanswered ends the request.
    localparam logic [WW-1:0] WAIT_LAST_C = (TIMEOUT <= 1) ? '0 : WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACTIVE, BACKOFF, RESP} state_t;

    state_t        state_q, state_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic          valid_q, valid_d;

    // Data-in tag carries nothing this master uses.
    logic unused_tgd;
    assign unused_tgd = ^wb_tgd_i;

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        wait_d  = wait_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_i) begin
                    adr_d   = addr_i;
                    dat_d   = data_i;
                    sel_d   = sel_i;
                    we_d    = we_i;
                    retry_d = '0;
                    wait_d  = '0;
                    state_d = ACTIVE;
                end
            end
            ACTIVE: begin
                // valid_d/err_d/rdata_d are loaded on the edge into RESP so
                // the response is visible for exactly the RESP cycle.
                if (wb_err_i) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else if (wb_ack_i) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b0;
                    if (!we_q) begin
                        rdata_d = wb_dat_i;
                    end
                end else if (wb_rty_i) begin
                    if (retry_q < MAX_RETRY_C) begin
                        retry_d = retry_q + RW'(1);
                        wait_d  = '0;
                        state_d = BACKOFF;
                    end else begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        err_d   = 1'b1;
                    end
                end else if (wait_q == WAIT_LAST_C) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    wait_d = wait_q + WW'(1);
                end
            end
            BACKOFF: begin
                state_d = ACTIVE;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            retry_q <= '0;
            wait_q  <= '0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
            wait_q  <= wait_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end

    assign ready_o  = (state_q == IDLE) && !rst_i;
    assign valid_o  = valid_q;
    assign data_o   = rdata_q;
    assign err_o    = err_q;

    assign wb_cyc_o = (state_q == ACTIVE);
    assign wb_stb_o = (state_q == ACTIVE);
    assign wb_we_o  = (state_q == ACTIVE) && we_q;
    assign wb_adr_o = adr_q;
    assign wb_dat_o = dat_q;
    assign wb_sel_o = sel_q;
    assign wb_tgd_o = '0;
    assign wb_tga_o = '0;
    assign wb_tgc_o = '0;

endmodule

// File: tb/tb_wishbone_req_master.sv
// tb/tb_wishbone_req_master.sv - directed self-checking bench for wishbone_req_master

module tb_wishbone_req_master;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] data_i;
    logic [3:0]  sel_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] data_o;
    logic        err_o;
    logic [31:0] wb_dat_i;
    logic [1:0]  wb_tgd_i;
    logic [31:0] wb_dat_o;
    logic [1:0]  wb_tgd_o;
    logic [31:0] wb_adr_o;
    logic [1:0]  wb_tga_o;
    logic [1:0]  wb_tgc_o;
    logic        wb_ack_i;
    logic        wb_err_i;
    logic        wb_rty_i;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;

    int tests_run    = 0;
    int tests_failed = 0;

    wishbone_req_master #(.TAGSIZE(2), .MAX_RETRY(3), .TIMEOUT(15)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i),
        .addr_i(addr_i), .data_i(data_i), .sel_i(sel_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o), .err_o(err_o),
        .wb_dat_i(wb_dat_i), .wb_tgd_i(wb_tgd_i), .wb_dat_o(wb_dat_o),
        .wb_tgd_o(wb_tgd_o), .wb_adr_o(wb_adr_o), .wb_tga_o(wb_tga_o),
        .wb_tgc_o(wb_tgc_o), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
        .wb_rty_i(wb_rty_i), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
        .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                         input logic [3:0] sel);
        req_i  = 1'b1;
        we_i   = we;
        addr_i = adr;
        data_i = dat;
        sel_i  = sel;
        step();
        // Scramble inputs so any late sampling shows up on the bus.
        req_i  = 1'b0;
        we_i   = ~we;
        addr_i = 32'hFFFF_0000;
        data_i = 32'h0BAD_0BAD;
        sel_i  = 4'h0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        step();
        step();
        tests_run++;
        if (ready_o !== 1'b0 || valid_o !== 1'b0 || wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_ctrl: ready=%b valid=%b cyc=%b stb=%b, required 0 0 0 0",
                     ready_o, valid_o, wb_cyc_o, wb_stb_o);
        end
        tests_run++;
        if (data_o !== 32'h0 || err_o !== 1'b0 || wb_adr_o !== 32'h0 || wb_dat_o !== 32'h0 ||
            wb_sel_o !== 4'h0 || wb_tgd_o !== 2'b0 || wb_tga_o !== 2'b0 || wb_tgc_o !== 2'b0) begin
            tests_failed++;
            $display("FAIL reset_regs: data=%h err=%b adr=%h dat=%h sel=%h tags=%b%b%b, required all 0",
                     data_o, err_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_tgd_o, wb_tga_o, wb_tgc_o);
        end
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release_ready: got %b, required 1", ready_o);
        end
    endtask

    task automatic test_read();
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL read_ready: got %b, required 1", ready_o);
        end
        issue(1'b0, 32'h0000_0100, 32'h0, 4'hF);
        tests_run++;
        if (wb_cyc_o !== 1'b1 || wb_stb_o !== 1'b1 || wb_we_o !== 1'b0 ||
            wb_adr_o !== 32'h0000_0100 || wb_sel_o !== 4'hF || ready_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_bus: cyc=%b stb=%b we=%b adr=%h sel=%h ready=%b, required 1 1 0 00000100 f 0",
                     wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, ready_o);
        end
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hDEAD_BEEF;
        step();
        wb_ack_i = 1'b0;
        wb_dat_i = 32'h0;
        tests_run++;
        if (valid_o !== 1'b1 || data_o !== 32'hDEAD_BEEF || err_o !== 1'b0 || wb_stb_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL read_resp: valid=%b data=%h err=%b stb=%b, required 1 deadbeef 0 0",
                     valid_o, data_o, err_o, wb_stb_o);
        end
        step();
        tests_run++;
        if (ready_o !== 1'b1 || valid_o !== 1'b0 || data_o !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL read_after: ready=%b valid=%b data=%h, required 1 0 deadbeef",
                     ready_o, valid_o, data_o);
        end
    endtask

    task automatic test_write();
        int bad = 0;
        issue(1'b1, 32'h0000_0200, 32'h1234_5678, 4'hF);
        for (int i = 0; i < 4; i++) begin
            if (wb_stb_o !== 1'b1 || wb_cyc_o !== 1'b1 || wb_we_o !== 1'b1 ||
                wb_dat_o !== 32'h1234_5678 || wb_adr_o !== 32'h0000_0200 ||
                wb_sel_o !== 4'hF || valid_o !== 1'b0) bad++;
            if (i == 3) wb_ack_i = 1'b1;
            wb_dat_i = 32'h7777_7777;
            step();
        end
        wb_ack_i = 1'b0;
        tests_run++;
        if (bad != 0) begin
            tests_failed++;
            $display("FAIL write_hold: %0d of 4 active cycles wrong, required 0", bad);
        end
        tests_run++;
        if (valid_o !== 1'b1 || err_o !== 1'b0 || data_o !== 32'hDEAD_BEEF || wb_we_o !== 1'b0) begin
            tests_failed++;
            $display("FAIL write_resp: valid=%b err=%b data=%h we=%b, required 1 0 deadbeef 0",
                     valid_o, err_o, data_o, wb_we_o);
        end
        step();
    endtask

    task automatic test_retry();
        int stb_cycles = 0;
        int attempts   = 0;
        int gaps       = 0;
        logic prev     = 1'b0;
        int c          = 0;
        issue(1'b0, 32'h0000_0300, 32'h0, 4'h3);
        wb_rty_i = 1'b1;
        while (!valid_o && c < 40) begin
            if (wb_stb_o) stb_cycles++;
            if (wb_stb_o && !prev) attempts++;
            if (!wb_cyc_o) gaps++;
            prev = wb_stb_o;
            step();
            c++;
        end
        wb_rty_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b1 || err_o !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL retry_resp: valid=%b err=%b data=%h, required 1 1 deadbeef",
                     valid_o, err_o, data_o);
        end
        tests_run++;
        if (attempts != 4 || stb_cycles != 4 || gaps != 3) begin
            tests_failed++;
            $display("FAIL retry_shape: attempts=%0d stb_cycles=%0d backoff=%0d, required 4 4 3",
                     attempts, stb_cycles, gaps);
        end
        step();
    endtask

    task automatic test_timeout();
        int stb_cycles = 0;
        int c          = 0;
        issue(1'b0, 32'h0000_0400, 32'h0, 4'hF);
        while (!valid_o && c < 40) begin
            if (wb_stb_o) stb_cycles++;
            step();
            c++;
        end
        tests_run++;
        if (valid_o !== 1'b1 || err_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL timeout_resp: valid=%b err=%b, required 1 1", valid_o, err_o);
        end
        tests_run++;
        if (stb_cycles != 15) begin
            tests_failed++;
            $display("FAIL timeout_len: stb cycles=%0d, required 15", stb_cycles);
        end
        step();
    endtask

    task automatic test_err_ack();
        issue(1'b0, 32'h0000_0500, 32'h0, 4'hF);
        wb_err_i = 1'b1;
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hCAFE_F00D;
        step();
        wb_err_i = 1'b0;
        wb_ack_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b1 || err_o !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL err_over_ack: valid=%b err=%b data=%h, required 1 1 deadbeef",
                     valid_o, err_o, data_o);
        end
        step();
    endtask

    task automatic test_ack_rty();
        issue(1'b0, 32'h0000_0600, 32'h0, 4'hF);
        tests_run++;
        if (err_o !== 1'b1 || data_o !== 32'hDEAD_BEEF) begin
            tests_failed++;
            $display("FAIL resp_hold: err=%b data=%h, required 1 deadbeef", err_o, data_o);
        end
        wb_ack_i = 1'b1;
        wb_rty_i = 1'b1;
        wb_dat_i = 32'h55AA_55AA;
        step();
        wb_ack_i = 1'b0;
        wb_rty_i = 1'b0;
        tests_run++;
        if (valid_o !== 1'b1 || err_o !== 1'b0 || data_o !== 32'h55AA_55AA) begin
            tests_failed++;
            $display("FAIL ack_over_rty: valid=%b err=%b data=%h, required 1 0 55aa55aa",
                     valid_o, err_o, data_o);
        end
        step();
    endtask

    task automatic test_reset_mid();
        int pulses = 0;
        issue(1'b1, 32'h0000_0700, 32'hAAAA_5555, 4'h1);
        rst_i    = 1'b1;
        wb_ack_i = 1'b1;
        step();
        wb_ack_i = 1'b0;
        tests_run++;
        if (wb_cyc_o !== 1'b0 || wb_stb_o !== 1'b0 || valid_o !== 1'b0 || ready_o !== 1'b0 ||
            data_o !== 32'h0 || wb_adr_o !== 32'h0) begin
            tests_failed++;
            $display("FAIL reset_mid: cyc=%b stb=%b valid=%b ready=%b data=%h adr=%h, required 0 0 0 0 0 0",
                     wb_cyc_o, wb_stb_o, valid_o, ready_o, data_o, wb_adr_o);
        end
        rst_i = 1'b0;
        #1;
        tests_run++;
        if (ready_o !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_ready: got %b, required 1", ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            if (valid_o !== 1'b0) pulses++;
        end
        tests_run++;
        if (pulses != 0) begin
            tests_failed++;
            $display("FAIL reset_mid_valid: %0d valid pulses, required 0", pulses);
        end
    endtask

    initial begin
        rst_i    = 1'b1;
        req_i    = 1'b0;
        we_i     = 1'b0;
        addr_i   = 32'h0;
        data_i   = 32'h0;
        sel_i    = 4'h0;
        wb_dat_i = 32'h0;
        wb_tgd_i = 2'b11;
        wb_ack_i = 1'b0;
        wb_err_i = 1'b0;
        wb_rty_i = 1'b0;
        test_reset();
        test_read();
        test_write();
        test_retry();
        test_timeout();
        test_err_ack();
        test_ack_rty();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
